// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM burst controller: FSM state encoding,
// inactive levels of the device strobes and the burst-length clamp.
// No ports; imported by psram_counter and psram_burst_controller.
package psram_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    LAT    = 3'd2,
    DATA   = 3'd3,
    CFG    = 3'd4,
    FINISH = 3'd5
  } psram_state_e;

  // Inactive levels of the device-side control signals.
  localparam logic STROBE_OFF = 1'b1;  // every *_L strobe
  localparam logic CRE_OFF    = 1'b0;
  localparam logic OE_OFF     = 1'b0;
  localparam logic CLK_OFF    = 1'b0;

  // A zero-length request still moves one word; oversize requests are cut
  // down to the largest burst the device accepts.
  function automatic int unsigned clamp_burst(input int unsigned req,
                                              input int unsigned max_len);
    if (req == 0) return 1;
    if (req > max_len) return max_len;
    return req;
  endfunction

endpackage

// File: rtl/psram_counter.sv
// Up-counter with enable, synchronous clear and terminal-count compare.
// Ports: clk_i, rst_i (async, active-high), en_i, clr_i, term_i -> done_o.
// done_o is combinational (count == term_i); clear has priority over enable.
module psram_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == term_i);

endmodule

// File: rtl/psram_burst_controller.sv
// Burst controller for a synchronous PSRAM: one host request becomes an
// ADDR / LAT / DATA / FINISH sequence (or ADDR-less CFG register write).
// Host side: baddr/bburst/bwe_L/benable_L/bcre request, bwdata/bbe_L with
//   bwready per write beat, brdata/brvalid per read beat, bbusy.
// Device side: maddr, mdq_out/mdq_oe/mdq_in, mbe_L, moe_L, mwe_L, madv_L,
//   mce_L, mcre, mclk_en, mwait.
// Define PSRAM_MWAIT_EN to honour mwait (extends LAT, stalls DATA beats);
// without it the timing is purely count-based and mwait is ignored.
module psram_burst_controller
  import psram_pkg::*;
#(
  parameter int A_WIDTH   = 24,
  parameter int D_WIDTH   = 16,
  parameter int LATENCY   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                       clk50MHz,
  input  logic                       rst,
  input  logic [A_WIDTH-1:0]         baddr,
  input  logic [$clog2(MAX_BURST):0] bburst,
  input  logic                       bwe_L,
  input  logic                       benable_L,
  input  logic                       bcre,
  input  logic [D_WIDTH-1:0]         bwdata,
  input  logic [D_WIDTH/8-1:0]       bbe_L,
  output logic                       bwready,
  output logic [D_WIDTH-1:0]         brdata,
  output logic                       brvalid,
  output logic                       bbusy,
  output logic [A_WIDTH-1:0]         maddr,
  output logic [D_WIDTH-1:0]         mdq_out,
  output logic                       mdq_oe,
  input  logic [D_WIDTH-1:0]         mdq_in,
  output logic [D_WIDTH/8-1:0]       mbe_L,
  output logic                       moe_L,
  output logic                       mwe_L,
  output logic                       madv_L,
  output logic                       mce_L,
  output logic                       mcre,
  output logic                       mclk_en,
  input  logic                       mwait
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int LW = 4;

  psram_state_e       state_q, state_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic               we_n_q, we_n_d;
  logic               cre_q, cre_d;
  logic [BW-1:0]      len_q, len_d;      // burst length minus one
  logic [D_WIDTH-1:0] brdata_q, brdata_d;
  logic               brvalid_q, brvalid_d;

  logic stall;
  logic beat;
  logic lat_done;
  logic burst_done;

`ifdef PSRAM_MWAIT_EN
  assign stall = mwait;
`else
  logic mwait_unused;
  assign mwait_unused = mwait;
  assign stall = 1'b0;
`endif

  // A beat is a DATA cycle the device is not stretching.
  assign beat = (state_q == DATA) && !stall;

  // LAT runs LATENCY-1 cycles: the count walks 0..LATENCY-2 and then holds
  // until the device releases mwait (when that handling is built in).
  psram_counter #(.W(LW)) u_lat_cnt (
    .clk_i  (clk50MHz),
    .rst_i  (rst),
    .en_i   ((state_q == LAT) && !lat_done),
    .clr_i  (state_q != LAT),
    .term_i (LW'(LATENCY - 2)),
    .done_o (lat_done)
  );

  psram_counter #(.W(BW)) u_burst_cnt (
    .clk_i  (clk50MHz),
    .rst_i  (rst),
    .en_i   (beat),
    .clr_i  (state_q != DATA),
    .term_i (len_q),
    .done_o (burst_done)
  );

  // Next-state and request capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_n_d  = we_n_q;
    cre_d   = cre_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (!benable_L) begin
          addr_d  = baddr;
          we_n_d  = bwe_L;
          cre_d   = bcre;
          len_d   = BW'(clamp_burst(32'(bburst), MAX_BURST) - 1);
          state_d = (bcre && !bwe_L) ? CFG : ADDR;
        end
      end
      ADDR:    state_d = LAT;
      LAT:     if (lat_done && !stall) state_d = DATA;
      DATA:    if (beat && burst_done) state_d = FINISH;
      CFG:     state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read beats are registered, so the last one is still on brdata in FINISH.
  always_comb begin
    brvalid_d = beat && we_n_q;
    brdata_d  = (beat && we_n_q) ? mdq_in : brdata_q;
  end

  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_n_q    <= 1'b1;
      cre_q     <= 1'b0;
      len_q     <= '0;
      brdata_q  <= '0;
      brvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_n_q    <= we_n_d;
      cre_q     <= cre_d;
      len_q     <= len_d;
      brdata_q  <= brdata_d;
      brvalid_q <= brvalid_d;
    end
  end

  assign brdata  = brdata_q;
  assign brvalid = brvalid_q;

  // Device strobes decode straight from the state register, so an async
  // reset drops them to their inactive levels immediately.
  always_comb begin
    maddr   = '0;
    mdq_out = '0;
    mdq_oe  = OE_OFF;
    mbe_L   = '1;
    moe_L   = STROBE_OFF;
    mwe_L   = STROBE_OFF;
    madv_L  = STROBE_OFF;
    mce_L   = STROBE_OFF;
    mcre    = CRE_OFF;
    mclk_en = CLK_OFF;
    bwready = 1'b0;
    bbusy   = (state_q != IDLE);
    case (state_q)
      ADDR: begin
        mce_L   = 1'b0;
        madv_L  = 1'b0;
        mwe_L   = we_n_q;
        mcre    = cre_q;   // configuration-register read
        maddr   = addr_q;
        mclk_en = 1'b1;
      end
      LAT: begin
        mce_L   = 1'b0;
        mclk_en = 1'b1;
      end
      DATA: begin
        mce_L   = 1'b0;
        mclk_en = 1'b1;
        if (we_n_q) begin
          moe_L = 1'b0;
          mbe_L = '0;
        end else begin
          mwe_L   = 1'b0;
          mdq_oe  = 1'b1;
          mdq_out = bwdata;
          mbe_L   = bbe_L;
          bwready = !stall;
        end
      end
      CFG: begin
        mcre    = 1'b1;
        mce_L   = 1'b0;
        madv_L  = 1'b0;
        mwe_L   = 1'b0;
        maddr   = addr_q;
        mclk_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_psram_burst_controller.sv
module tb_psram_burst_controller;

  localparam int AW    = 24;
  localparam int DW    = 16;
  localparam int LAT_P = 4;
  localparam int MB    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] baddr;
  logic [4:0]    bburst;
  logic          bwe_L, benable_L, bcre;
  logic [DW-1:0] bwdata;
  logic [1:0]    bbe_L;
  logic          bwready;
  logic [DW-1:0] brdata;
  logic          brvalid, bbusy;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdq_out, mdq_in;
  logic          mdq_oe;
  logic [1:0]    mbe_L;
  logic          moe_L, mwe_L, madv_L, mce_L, mcre, mclk_en, mwait;

  psram_burst_controller #(
    .A_WIDTH(AW), .D_WIDTH(DW), .LATENCY(LAT_P), .MAX_BURST(MB)
  ) dut (
    .clk50MHz(clk), .rst(rst), .baddr(baddr), .bburst(bburst), .bwe_L(bwe_L),
    .benable_L(benable_L), .bcre(bcre), .bwdata(bwdata), .bbe_L(bbe_L),
    .bwready(bwready), .brdata(brdata), .brvalid(brvalid), .bbusy(bbusy),
    .maddr(maddr), .mdq_out(mdq_out), .mdq_oe(mdq_oe), .mdq_in(mdq_in),
    .mbe_L(mbe_L), .moe_L(moe_L), .mwe_L(mwe_L), .madv_L(madv_L),
    .mce_L(mce_L), .mcre(mcre), .mclk_en(mclk_en), .mwait(mwait)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards and per-test statistics.
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] wr_q[$];
  logic [1:0]    be_exp;
  int cyc = 0;
  int adv_cyc, adv_cnt, first_vld, last_vld, vld_total, run, max_run;
  int bwr_total, mcre_cnt, oe_cnt, oe_bad, rd_be_bad;
  logic [AW-1:0] mcre_addr;
  logic [AW-1:0] dev_addr;
  logic [7:0]    dev_beat;

  initial forever @(posedge clk) cyc++;

  task automatic clear_stats();
    adv_cyc = 0; adv_cnt = 0; first_vld = -1; last_vld = -1; vld_total = 0;
    run = 0; max_run = 0; bwr_total = 0; mcre_cnt = 0; oe_cnt = 0; oe_bad = 0;
    rd_be_bad = 0; mcre_addr = '0;
  endtask

  // Negedge monitor plus a tiny device model: read data is address + beat.
  initial begin
    dev_addr = '0; dev_beat = '0; mdq_in = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0; dev_addr = '0; dev_beat = '0; mdq_in = '0;
      end else begin
        if (!madv_L) begin adv_cnt++; adv_cyc = cyc; end
        if (brvalid) begin
          if (first_vld < 0) first_vld = cyc;
          last_vld = cyc;
          vld_total++; run++;
          if (run > max_run) max_run = run;
          if (rd_q.size() == 0) check("rd_extra", 1, 0);
          else check("rd_data", 32'(brdata), 32'(rd_q.pop_front()));
        end else run = 0;
        if (bwready) begin
          bwr_total++;
          if (wr_q.size() == 0) check("wr_extra", 1, 0);
          else begin
            check("wr_data", 32'(mdq_out), 32'(wr_q.pop_front()));
            check("wr_be", 32'(mbe_L), 32'(be_exp));
          end
          bwdata = (wr_q.size() != 0) ? wr_q[0] : '0;
        end
        if (mdq_oe) begin
          oe_cnt++;
          if (mwe_L || !moe_L) oe_bad++;
        end
        if (!moe_L && mbe_L != 2'b00) rd_be_bad++;
        if (mcre) begin mcre_cnt++; mcre_addr = maddr; end
        if (!madv_L) begin dev_addr = maddr; dev_beat = '0; end
        mdq_in = dev_addr[15:0] + 16'(dev_beat);
`ifdef PSRAM_MWAIT_EN
        if (!moe_L && !mwait) dev_beat++;
`else
        if (!moe_L) dev_beat++;
`endif
      end
    end
  end

  task automatic req(input logic [AW-1:0] a, input logic [4:0] n,
                     input logic we_n, input logic cre, input logic [1:0] be);
    @(posedge clk); #1;
    baddr = a; bburst = n; bwe_L = we_n; bcre = cre; bbe_L = be; benable_L = 1'b0;
    @(posedge clk); #1;
    benable_L = 1'b1;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    for (int i = 0; i < bound && bbusy; i++) @(negedge clk);
    check(tag, 32'(bbusy), 0);
  endtask

  task automatic push_reads(input logic [AW-1:0] a, input int n);
    for (int k = 0; k < n; k++) rd_q.push_back(a[15:0] + 16'(k));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; baddr = '0; bburst = '0; bwe_L = 1'b1; benable_L = 1'b1;
    bcre = 1'b0; bwdata = '0; bbe_L = 2'b11; mwait = 1'b0; be_exp = 2'b00;
    clear_stats();
    repeat (3) @(posedge clk); #1;
    check("rst_bbusy",   32'(bbusy), 0);
    check("rst_mce",     32'(mce_L), 1);
    check("rst_madv",    32'(madv_L), 1);
    check("rst_moe",     32'(moe_L), 1);
    check("rst_mwe",     32'(mwe_L), 1);
    check("rst_mbe",     32'(mbe_L), 32'h3);
    check("rst_mcre",    32'(mcre), 0);
    check("rst_mclk_en", 32'(mclk_en), 0);
    check("rst_mdq_oe",  32'(mdq_oe), 0);
    check("rst_bwready", 32'(bwready), 0);
    check("rst_brvalid", 32'(brvalid), 0);
    check("rst_brdata",  32'(brdata), 0);
    check("rst_mdq_out", 32'(mdq_out), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Read, 4 beats at 0x000100.
    clear_stats(); push_reads(24'h000100, 4);
    req(24'h000100, 5'd4, 1'b1, 1'b0, 2'b11);
    wait_idle(40, "rd4_idle");
    check("rd4_adv_cnt", 32'(adv_cnt), 1);
    check("rd4_first_lat", 32'(first_vld - adv_cyc), LAT_P + 1);
    check("rd4_run", 32'(max_run), 4);
    check("rd4_total", 32'(vld_total), 4);
    check("rd4_idle_after_finish", 32'(cyc - last_vld), 1);
    check("rd4_be_zero", 32'(rd_be_bad), 0);
    check("rd4_q_empty", 32'(rd_q.size()), 0);

    // Write, 2 beats.
    clear_stats();
    wr_q.push_back(16'hA5A5); wr_q.push_back(16'h5A5A);
    be_exp = 2'b01; bwdata = wr_q[0];
    req(24'h000200, 5'd2, 1'b0, 1'b0, 2'b01);
    wait_idle(40, "wr2_idle");
    check("wr2_beats", 32'(bwr_total), 2);
    check("wr2_oe_cycles", 32'(oe_cnt), 2);
    check("wr2_oe_bad", 32'(oe_bad), 0);
    check("wr2_q_empty", 32'(wr_q.size()), 0);
    bbe_L = 2'b11;

    // Zero-length burst is one beat.
    clear_stats(); push_reads(24'h000300, 1);
    req(24'h000300, 5'd0, 1'b1, 1'b0, 2'b11);
    wait_idle(40, "b0_idle");
    check("b0_total", 32'(vld_total), 1);

    // Oversize burst clamps to MAX_BURST.
    clear_stats(); push_reads(24'h000400, MB);
    req(24'h000400, 5'd31, 1'b1, 1'b0, 2'b11);
    wait_idle(80, "b31_idle");
    check("b31_total", 32'(vld_total), MB);
    check("b31_run", 32'(max_run), MB);
    check("b31_q_empty", 32'(rd_q.size()), 0);

    // Configuration-register write.
    clear_stats();
    req(24'h080010, 5'd1, 1'b0, 1'b1, 2'b11);
    begin
      int t0;
      t0 = cyc;
      wait_idle(20, "cfg_idle");
      check("cfg_idle_delay", 32'(cyc - t0), 2);
    end
    check("cfg_mcre_cycles", 32'(mcre_cnt), 1);
    check("cfg_maddr", 32'(mcre_addr), 32'h080010);
    check("cfg_no_bwready", 32'(bwr_total), 0);

    // A request while busy is dropped.
    clear_stats(); push_reads(24'h000500, 2);
    req(24'h000500, 5'd2, 1'b1, 1'b0, 2'b11);
    baddr = 24'h000900; benable_L = 1'b0;
    repeat (2) @(posedge clk); #1;
    benable_L = 1'b1;
    wait_idle(40, "busy_idle");
    repeat (8) @(posedge clk); #1;
    check("busy_adv_cnt", 32'(adv_cnt), 1);
    check("busy_total", 32'(vld_total), 2);
    check("busy_still_idle", 32'(bbusy), 0);

    // mwait raised for 3 cycles at read beat 2 of 4.
    clear_stats(); push_reads(24'h000600, 4);
    req(24'h000600, 5'd4, 1'b1, 1'b0, 2'b11);
    for (int i = 0; i < 20 && adv_cnt == 0; i++) @(negedge clk);
    for (int i = 0; i < 20 && cyc < adv_cyc + LAT_P + 1; i++) @(negedge clk);
    @(posedge clk); #1; mwait = 1'b1;
    repeat (3) @(posedge clk); #1; mwait = 1'b0;
    wait_idle(40, "mw_idle");
    check("mw_total", 32'(vld_total), 4);
`ifdef PSRAM_MWAIT_EN
    check("mw_run", 32'(max_run), 2);
    check("mw_span", 32'(last_vld - first_vld), 6);
`else
    check("mw_run", 32'(max_run), 4);
    check("mw_span", 32'(last_vld - first_vld), 3);
`endif
    check("mw_q_empty", 32'(rd_q.size()), 0);

    // Reset at write beat 3 of 8.
    clear_stats();
    for (int k = 0; k < 8; k++) wr_q.push_back(16'h1000 + 16'(k));
    be_exp = 2'b00; bwdata = wr_q[0];
    req(24'h000700, 5'd8, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 30 && bwr_total < 2; i++) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_mce", 32'(mce_L), 1);
    check("arst_bwready", 32'(bwready), 0);
    check("arst_bbusy", 32'(bbusy), 0);
    check("arst_mdq_oe", 32'(mdq_oe), 0);
    wr_q.delete(); bwdata = '0; bbe_L = 2'b11;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("arst_beats", 32'(bwr_total), 2);
    check("arst_stays_idle", 32'(bbusy), 0);

    clear_stats(); push_reads(24'h000800, 3);
    req(24'h000800, 5'd3, 1'b1, 1'b0, 2'b11);
    wait_idle(40, "post_rst_idle");
    check("post_rst_total", 32'(vld_total), 3);
    check("post_rst_lat", 32'(first_vld - adv_cyc), LAT_P + 1);
    check("post_rst_q_empty", 32'(rd_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
